// File: rtl/serial_word_receiver.sv
// rtl/serial_word_receiver.sv - serial frame receiver with one-entry valid/ready output buffer
//
// Reassembles framed serial words (start 0, WIDTH data bits, stop 1) sampled on
// an external bit strobe and presents each good word through a one-entry buffer.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_bit_en     bit strobe; i_ser_in is sampled only when high
//   i_ser_in     serial line, idles high
//   i_out_ready  downstream accepts o_out_data this cycle
//   o_out_data   received word, stable while o_out_valid is high
//   o_out_valid  o_out_data holds an unconsumed word
//   o_frame_err  one-cycle pulse: stop bit sampled as 0
//   o_overrun    one-cycle pulse: good word dropped, buffer full
//   o_busy       receiver is inside a frame (state != IDLE)
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_bit_en,
  input  logic             i_ser_in,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             w_load;
  logic             w_ferr;
  logic             w_ovr;
  logic             w_xfer;
  logic [WIDTH-1:0] w_shifted;

  assign w_xfer    = r_valid & i_out_ready;
  assign w_shifted = LSB_FIRST ? {i_ser_in, r_shreg[WIDTH-1:1]}
                               : {r_shreg[WIDTH-2:0], i_ser_in};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shreg_next = r_shreg;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    w_ovr        = 1'b0;
    if (i_bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!i_ser_in) begin
            w_state_next = S_DATA;
            w_cnt_next   = '0;
          end
        end
        S_DATA: begin
          w_shreg_next = w_shifted;
          if (r_cnt == LAST_BIT) begin
            w_state_next = S_STOP;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          w_state_next = S_IDLE;
          if (i_ser_in) begin
            // A transfer in this same cycle frees the buffer for the new word.
            if (!r_valid || i_out_ready) w_load = 1'b1;
            else                         w_ovr  = 1'b1;
          end else begin
            // Bad stop bit is not reused as a start bit.
            w_ferr = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shreg <= w_shreg_next;
      r_ferr  <= w_ferr;
      r_ovr   <= w_ovr;
      if (w_load) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_frame_err = r_ferr;
  assign o_overrun   = r_ovr;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb/tb_serial_word_receiver.sv - self-checking bench for serial_word_receiver (both bit orders)
module tb_serial_word_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ben;
  logic         sin;
  logic         rdy;
  logic [W-1:0] d_l, d_m;
  logic         v_l, v_m, fe_l, fe_m, ov_l, ov_m, b_l, b_m;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_l, exp_m, cur_l, cur_m;
  logic         exp_valid, exp_ferr, exp_ovr, exp_busy;

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk(clk), .i_reset(rst), .i_bit_en(ben), .i_ser_in(sin), .i_out_ready(rdy),
    .o_out_data(d_l), .o_out_valid(v_l), .o_frame_err(fe_l), .o_overrun(ov_l), .o_busy(b_l)
  );

  serial_word_receiver #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .i_clk(clk), .i_reset(rst), .i_bit_en(ben), .i_ser_in(sin), .i_out_ready(rdy),
    .o_out_data(d_m), .o_out_valid(v_m), .o_frame_err(fe_m), .o_overrun(ov_m), .o_busy(b_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_data_lsb"},  32'(d_l),  32'(exp_l));
    chk({tag, "_data_msb"},  32'(d_m),  32'(exp_m));
    chk({tag, "_valid_lsb"}, 32'(v_l),  32'(exp_valid));
    chk({tag, "_valid_msb"}, 32'(v_m),  32'(exp_valid));
    chk({tag, "_ferr_lsb"},  32'(fe_l), 32'(exp_ferr));
    chk({tag, "_ferr_msb"},  32'(fe_m), 32'(exp_ferr));
    chk({tag, "_ovr_lsb"},   32'(ov_l), 32'(exp_ovr));
    chk({tag, "_ovr_msb"},   32'(ov_m), 32'(exp_ovr));
    chk({tag, "_busy_lsb"},  32'(b_l),  32'(exp_busy));
    chk({tag, "_busy_msb"},  32'(b_m),  32'(exp_busy));
  endtask

  // Word as seen by each bit order when line bits are v[0], v[1], ... in time order.
  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = v[i];
    return r;
  endfunction

  // Buffer model: one-entry holding register fed by completed frames.
  task automatic tick_check(input string tag, input bit is_stop, input bit stop_good);
    bit load;
    load     = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (is_stop && stop_good) begin
      if (!exp_valid || rdy) load = 1'b1;
      else                   exp_ovr = 1'b1;
    end
    if (is_stop && !stop_good) exp_ferr = 1'b1;
    if (load) begin
      exp_valid = 1'b1;
      exp_l     = cur_l;
      exp_m     = cur_m;
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic strobe(input string tag, input logic b, input int gap, input bit is_stop,
                        input bit busy_after);
    for (int g = 0; g < gap; g++) begin
      ben = 1'b0;
      sin = 1'($urandom % 2);
      tick_check({tag, "_gap"}, 1'b0, 1'b0);
    end
    ben      = 1'b1;
    sin      = b;
    exp_busy = busy_after;
    tick_check(tag, is_stop, b);
    ben = 1'b0;
    sin = 1'b1;
  endtask

  task automatic send_frame(input string tag, input logic [W-1:0] v, input bit stop_good,
                            input int gap, input logic rdy_at_stop);
    cur_l = v;
    cur_m = rev(v);
    strobe({tag, "_start"}, 1'b0, gap, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) strobe({tag, "_bit"}, v[i], gap, 1'b0, 1'b1);
    rdy = rdy_at_stop;
    strobe({tag, "_stop"}, stop_good, gap, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    ben = 1'($urandom % 2);
    @(posedge clk);
    #1;
    exp_l = '0; exp_m = '0; exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_busy = 1'b0;
    compare_all(tag);
    rst = 1'b0;
    ben = 1'b0;
    sin = 1'b1;
  endtask

  task automatic idle_ticks(input string tag, input int n, input logic r);
    rdy = r;
    for (int i = 0; i < n; i++) tick_check(tag, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ben = 1'b0; sin = 1'b1; rdy = 1'b0;
    cur_l = '0; cur_m = '0;
    exp_l = '0; exp_m = '0; exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_busy = 1'b0;

    do_reset("reset");

    // 0,1,0,1 on the line: 4'hA LSB-first, 4'h5 MSB-first.
    rdy = 1'b0;
    send_frame("basic", 4'hA, 1'b1, 0, 1'b0);
    chk("basic_value_lsb", 32'(d_l), 32'hA);
    chk("basic_value_msb", 32'(d_m), 32'h5);
    idle_ticks("basic_drain", 2, 1'b1);

    // Strobe every third cycle.
    rdy = 1'b0;
    send_frame("slow", 4'hA, 1'b1, 2, 1'b0);
    idle_ticks("slow_drain", 2, 1'b1);

    // Bad stop bit, then a good frame.
    rdy = 1'b0;
    send_frame("ferr", 4'hC, 1'b0, 0, 1'b0);
    idle_ticks("ferr_after", 2, 1'b0);
    send_frame("after_ferr", 4'h3, 1'b1, 1, 1'b0);
    idle_ticks("after_ferr_drain", 2, 1'b1);

    // Overrun with full buffer, then load during a transfer cycle.
    rdy = 1'b0;
    send_frame("ovr_a", 4'h1, 1'b1, 0, 1'b0);
    send_frame("ovr_b", 4'h2, 1'b1, 0, 1'b0);
    chk("ovr_held_lsb", 32'(d_l), 32'h1);
    idle_ticks("ovr_hold", 2, 1'b0);
    send_frame("ovr_c", 4'h7, 1'b1, 0, 1'b1);
    chk("ovr_replace_lsb", 32'(d_l), 32'h7);
    chk("ovr_replace_valid", 32'(v_l), 32'h1);
    rdy = 1'b0;
    idle_ticks("ovr_drain", 2, 1'b1);

    // Reset in the middle of a frame.
    rdy = 1'b0;
    cur_l = 4'hF; cur_m = 4'hF;
    strobe("part_start", 1'b0, 0, 1'b0, 1'b1);
    strobe("part_b0", 1'b1, 0, 1'b0, 1'b1);
    strobe("part_b1", 1'b1, 0, 1'b0, 1'b1);
    do_reset("mid_reset");
    idle_ticks("post_reset", 3, 1'b0);
    send_frame("after_reset", 4'h9, 1'b1, 0, 1'b0);
    idle_ticks("after_reset_drain", 2, 1'b1);

    // Idle line with toggling strobe.
    rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ben = 1'(i % 2);
      sin = 1'b1;
      tick_check("idle_line", 1'b0, 1'b0);
    end
    ben = 1'b0;

    // Randomized frames, gaps, stop bits and downstream readiness.
    for (int f = 0; f < 30; f++) begin
      logic [W-1:0] v;
      v   = W'($urandom_range(0, 15));
      rdy = 1'($urandom % 2);
      send_frame("rand", v, ($urandom_range(0, 4) != 0), $urandom_range(0, 3),
                 1'($urandom % 2));
      idle_ticks("rand_idle", $urandom_range(0, 2), 1'($urandom % 2));
    end
    idle_ticks("final_drain", 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receive end of the serial shift link; reassembles framed serial words back into parallel words.
- Frame on the line: one start bit (0), WIDTH data bits, one stop bit (1). The line idles high.
- Bits are sampled on an external bit-rate strobe (bit_en), not on every clock.
- Completed words are held in a one-entry output buffer with a valid/ready handshake to downstream logic.

Parameters:
- WIDTH, 4, number of data bits per frame (legal range 2..32).
- LSB_FIRST, 1, 1 = first data bit received lands in out_data[0]; 0 = first data bit received lands in out_data[WIDTH-1].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; ser_in is sampled only in cycles where bit_en=1.
- ser_in  input  1  serial line; idles at 1.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  received word; stable while out_valid=1.
- out_valid  output  1  out_data holds an unconsumed word.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: good word dropped because the buffer was full.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - state=IDLE, bit counter=0, shift register=0.
  - out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0.
  - reset has priority over every other event; a frame in progress is abandoned and not delivered.
- Serial side: FSM states IDLE, DATA, STOP. The FSM advances only in cycles with bit_en=1; with bit_en=0 the state, counter and shift register hold.
- IDLE: on bit_en=1 and ser_in=0 (start bit), go to DATA with counter=0. On bit_en=1 and ser_in=1, stay in IDLE.
- DATA, on each bit_en=1:
  - LSB_FIRST=1: shreg <= {ser_in, shreg[WIDTH-1:1]}.
  - LSB_FIRST=0: shreg <= {shreg[WIDTH-2:0], ser_in}.
  - Increment the counter; when counter==WIDTH-1 on this strobe, go to STOP. Exactly WIDTH data bits are captured.
- STOP, on bit_en=1:
  - ser_in=1 (good frame): try to load the buffer, then go to IDLE.
  - ser_in=0: pulse frame_err for one cycle, discard the word, go to IDLE. This 0 is not treated as a new start bit; the next start bit is looked for on the next strobe.
- Buffer load for a good frame, evaluated in the stop-sampling cycle:
  - If out_valid=0, or out_valid=1 and out_ready=1 in that same cycle: out_data<=shreg, out_valid<=1 from the next cycle. No overrun.
  - Otherwise: the held word is kept unchanged, the new word is dropped, and overrun pulses for one cycle.
- Handshake:
  - A transfer occurs in any cycle with out_valid=1 and out_ready=1.
  - After a transfer, out_valid clears on the next edge unless a new word loads in that same cycle, in which case out_valid stays 1 with the new data.
  - out_ready while out_valid=0 has no effect.
  - out_data does not change while out_valid=1 except through a load in a transfer cycle.
- Latency: out_valid rises in the cycle after the clk edge where bit_en=1 samples a good stop bit. A full frame takes WIDTH+2 bit_en strobes.
- frame_err and overrun are registered outputs; each is high for exactly one clk cycle per event, independent of bit_en spacing.
- The design must handle both back-to-back strobes (bit_en held at 1) and arbitrary gaps between strobes.

Test Plan:
- WIDTH=4, LSB_FIRST=1, bit_en=1 continuously, line 0,0,1,0,1,1 (start, data 0-1-0-1, stop) -> out_data=4'hA, out_valid=1 one cycle after the stop sample; frame_err=0, overrun=0; out_ready=1 then clears out_valid on the next edge.
- Same stimulus with LSB_FIRST=0 -> out_data=4'h5. Repeat with bit_en asserted every 3rd cycle -> identical result, with busy high from the start strobe until the stop strobe.
- Frame 0xC with stop bit 0 -> one-cycle frame_err pulse, out_valid stays 0, FSM in IDLE; a following good frame 0x3 is received correctly.
- out_ready=0; frames 0x1 then 0x2 -> out_data stays 4'h1, overrun pulses once at the second stop sample. Then out_ready=1 in the same cycle as a third frame 0x7 stop sample -> out_data=4'h7, out_valid stays 1, no overrun.
- reset=1 for one cycle after the 2nd data bit -> all outputs 0, busy=0; the partial word is never delivered, and the next full frame 0x9 is received correctly.
- Line held at 1 with bit_en toggling for 20 strobes -> out_valid, frame_err and busy all remain 0.
